// File: rtl/conv_window_gen_if.sv
// Pixel-stream / window bus between the raster source, the window generator
// and the convolution calc stage.
interface conv_window_gen_if #(
  parameter int KERNEL = 3,
  parameter int N      = 4
);
  logic [N-1:0]               pix_in;
  logic                       pix_valid;
  logic                       sof;
  logic [KERNEL*KERNEL*N-1:0] data2conv;
  logic                       en_out;
  logic                       last_out;

  modport master (
    output pix_in, pix_valid, sof,
    input  data2conv, en_out, last_out
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output data2conv, en_out, last_out
  );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding KERNEL x KERNEL window generator: KERNEL-1 line buffers feed a register
// window that is presented, one cycle after the completing pixel, to the calc stage.
module conv_window_gen #(
  parameter int KERNEL = 3,
  parameter int N      = 4,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic            clk,
  input  logic            rst,
  conv_window_gen_if.slave bus
);

  localparam int WIN_W = KERNEL * KERNEL * N;
  localparam int LB    = (KERNEL > 1) ? KERNEL - 1 : 1;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_eff_p0;
  logic [RW-1:0]    row_eff_p0;
  logic [LB*N-1:0]  lb_rd_p0;
  logic             pos_ok_p0;
  logic [WIN_W-1:0] win_p1_q, win_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic             last_p1_q, last_p1_d;

  // ---- p0: position of the pixel being accepted; sof forces (0,0) ----
  always_comb begin
    col_eff_p0 = col_q;
    row_eff_p0 = row_q;
    if (bus.pix_valid && bus.sof) begin
      col_eff_p0 = '0;
      row_eff_p0 = '0;
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.pix_valid) begin
      if (col_eff_p0 == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff_p0 == ROW_LAST) ? '0 : row_eff_p0 + RW'(1);
      end else begin
        col_d = col_eff_p0 + CW'(1);
        row_d = row_eff_p0;
      end
    end
  end

  generate
    if (KERNEL > 1) begin : g_lb
      // Line k holds the row k+1 rows above the current one; read-before-write
      // at the same column means the read returns the previous row's pixel.
      logic [N-1:0] lb_mem [LB][IMG_W];

      for (genvar k = 0; k < LB; k++) begin : g_rd
        assign lb_rd_p0[k*N +: N] = lb_mem[k][col_eff_p0];
      end

      always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
          lb_mem[0][col_eff_p0] <= bus.pix_in;
          for (int k = 1; k < LB; k++) begin
            lb_mem[k][col_eff_p0] <= lb_mem[k-1][col_eff_p0];
          end
        end
      end

      // Windows only once KERNEL-1 full rows and KERNEL columns of this row exist,
      // so neither stale line-buffer data nor the previous row's tail leaks in.
      assign pos_ok_p0 = (row_eff_p0 >= RW'(KERNEL - 1)) &&
                         (col_eff_p0 >= CW'(KERNEL - 1));
    end else begin : g_nolb
      assign lb_rd_p0  = '0;
      assign pos_ok_p0 = 1'b1;
    end
  endgenerate

  // Shift every row left and bring in the new column {line buffers, pix_in}.
  always_comb begin
    win_p1_d = win_p1_q;
    if (bus.pix_valid) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL - 1; c++) begin
          win_p1_d[(r*KERNEL + c)*N +: N] = win_p1_q[(r*KERNEL + c + 1)*N +: N];
        end
        if (r == KERNEL - 1) begin
          win_p1_d[(r*KERNEL + KERNEL - 1)*N +: N] = bus.pix_in;
        end else begin
          win_p1_d[(r*KERNEL + KERNEL - 1)*N +: N] =
            lb_rd_p0[((r < KERNEL - 1) ? (KERNEL - 2 - r) : 0)*N +: N];
        end
      end
    end
  end

  always_comb begin
    vld_p1_d  = bus.pix_valid && pos_ok_p0;
    last_p1_d = vld_p1_d && (row_eff_p0 == ROW_LAST) && (col_eff_p0 == COL_LAST);
  end

  // ---- p1: registered window and enable toward the calc stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      win_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_p1_q  <= win_p1_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
    end
  end

  assign bus.data2conv = win_p1_q;
  assign bus.en_out    = vld_p1_q;
  assign bus.last_out  = last_p1_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 5x4 image: a KERNEL=3 instance and a
// KERNEL=1 instance, with windows predicted from pixel coordinates.
module tb_conv_window_gen;

  localparam int N  = 4;
  localparam int W  = 5;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_gen_if #(.KERNEL(3), .N(N)) bus3 ();
  conv_window_gen_if #(.KERNEL(1), .N(N)) bus1 ();

  conv_window_gen #(.KERNEL(3), .N(N), .IMG_W(W), .IMG_H(H)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  conv_window_gen #(.KERNEL(1), .N(N), .IMG_W(W), .IMG_H(H)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_en    = 0;
  logic        prev_en;
  logic [35:0] last_win;
  logic [35:0] first_obs;
  logic [35:0] last_obs;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pval(int r, int c, int off);
    return 4'((r*W + c + off) % 16);
  endfunction

  function automatic logic [35:0] exp_win(int rr, int cc, int off);
    logic [35:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(r*3 + c)*4 +: 4] = pval(rr - 2 + r, cc - 2 + c, off);
    return w;
  endfunction

  // One accepted pixel at logical frame position (r,c) on the KERNEL=3 DUT.
  task automatic px(input int r, input int c, input bit s, input int off);
    logic exp_en;
    bus3.pix_in    = pval(r, c, off);
    bus3.pix_valid = 1'b1;
    bus3.sof       = s;
    @(posedge clk); #1;
    bus3.pix_valid = 1'b0;
    bus3.sof       = 1'b0;
    exp_en = (r >= 2) && (c >= 2);
    check("en_out", bus3.en_out, exp_en);
    if (exp_en) begin
      check("window", bus3.data2conv, exp_win(r, c, off));
      check("last_out", bus3.last_out, (r == H-1) && (c == W-1));
      if (n_en == 0) first_obs = bus3.data2conv;
      if (bus3.last_out) last_obs = bus3.data2conv;
      n_en++;
      last_win = exp_win(r, c, off);
      prev_en  = 1'b1;
    end else begin
      check("last_out_idle", bus3.last_out, 1'b0);
      prev_en = 1'b0;
    end
  endtask

  task automatic gap(input bit s);
    bus3.pix_valid = 1'b0;
    bus3.sof       = s;
    bus3.pix_in    = 4'hF;
    @(posedge clk); #1;
    bus3.sof = 1'b0;
    check("gap_en", bus3.en_out, 1'b0);
    check("gap_last", bus3.last_out, 1'b0);
    if (prev_en) check("gap_hold", bus3.data2conv, last_win);
  endtask

  task automatic frame(input bit sof_first, input int off, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (gaps) while ($urandom_range(0, 1) == 1) gap(1'($urandom_range(0, 1)));
        px(r, c, sof_first && r == 0 && c == 0, off);
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus3.pix_valid = 1'b0;
    bus3.sof = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_en", bus3.en_out, 1'b0);
    check("rst_last", bus3.last_out, 1'b0);
    check("rst_data", bus3.data2conv, 36'h0);
    prev_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    prev_en = 1'b0;
    last_win = '0;
    first_obs = '0;
    last_obs = '0;
    bus3.pix_in = '0; bus3.pix_valid = 1'b0; bus3.sof = 1'b0;
    bus1.pix_in = '0; bus1.pix_valid = 1'b0; bus1.sof = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", bus3.en_out, 1'b0);
    check("reset_last", bus3.last_out, 1'b0);
    check("reset_data", bus3.data2conv, 36'h0);
    check("reset_en_k1", bus1.en_out, 1'b0);
    rst = 1'b0;

    // Continuous frame with sof
    n_en = 0;
    frame(1'b1, 0, 1'b0);
    check("s1_count", 64'(n_en), 64'd6);
    check("s1_first_win", first_obs, 36'hCBA765210);
    check("s1_last_win", last_obs, 36'h321EDC987);
    gap(1'b0);

    // Random gaps, with stray sof in gap cycles
    n_en = 0;
    frame(1'b1, 0, 1'b1);
    check("s2_count", 64'(n_en), 64'd6);

    // Two back-to-back frames relying on the implicit wrap
    n_en = 0;
    frame(1'b0, 0, 1'b0);
    frame(1'b0, 0, 1'b0);
    check("s3_count", 64'(n_en), 64'd12);

    // Reset after pixel 15, then restart without sof
    for (int p = 0; p < 16; p++) px(p / W, p % W, p == 0, 0);
    do_reset();
    n_en = 0;
    frame(1'b0, 0, 1'b0);
    check("s4_count", 64'(n_en), 64'd6);
    check("s4_first_win", first_obs, 36'hCBA765210);

    // Partial frame with different data, then sof mid-frame at pixel 8
    for (int p = 0; p < 8; p++) px(p / W, p % W, p == 0, 9);
    n_en = 0;
    frame(1'b1, 0, 1'b0);
    check("s5_count", 64'(n_en), 64'd6);

    // KERNEL=1 instance: every valid pixel yields a one-pixel window
    n_en = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        bus1.pix_in    = pval(r, c, 3);
        bus1.pix_valid = 1'b1;
        bus1.sof       = (r == 0 && c == 0);
        @(posedge clk); #1;
        bus1.pix_valid = 1'b0;
        bus1.sof       = 1'b0;
        check("k1_en", bus1.en_out, 1'b1);
        check("k1_data", bus1.data2conv, pval(r, c, 3));
        check("k1_last", bus1.last_out, (r == H-1) && (c == W-1));
        if (bus1.en_out) n_en++;
        if (c == 2) begin
          @(posedge clk); #1;
          check("k1_gap_en", bus1.en_out, 1'b0);
        end
      end
    check("k1_count", 64'(n_en), 64'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
